// File: rtl/qwi_reg_master.sv
// qwi_reg_master: initiator for the single-cycle register bus.
// Turns valid/ready commands into single or auto-incrementing burst accesses and
// returns read data or a write ack on a response stream.
// Ports:
//   reg_clk, sys_rst_n                  clock, async active-low reset
//   cmd_valid/ready, cmd_wr/addr/len    command stream (len = beats-1)
//   wd_valid/ready, wd_data             write-data beat stream
//   rsp_valid/ready, rsp_data/last      response stream (data 0 for write ack)
//   busy                                controller not idle
//   reg_ce/we/addr/wrd, reg_rdd         register bus (rdd combinational from addr)
module qwi_reg_master #(
    parameter int unsigned AWID   = 12,
    parameter int unsigned DWID   = 32,
    parameter int unsigned LENW   = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              reg_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [AWID-1:0]   cmd_addr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DWID-1:0]   wd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWID-1:0]   rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              reg_ce,
    output logic [DWID/8-1:0] reg_we,
    output logic [AWID-1:0]   reg_addr,
    output logic [DWID-1:0]   reg_wrd,
    input  logic [DWID-1:0]   reg_rdd
);

    // RWAIT counter preload: sample happens RD_LAT cycles after the RADDR cycle
    localparam int unsigned WAIT_INIT = (RD_LAT == 0) ? 0 : RD_LAT - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WACK,
        S_RADDR,
        S_RWAIT,
        S_RRESP
    } state_t;

    state_t          state;
    logic [AWID-1:0] cur_addr;
    logic [LENW-1:0] beats;
    logic [2:0]      wait_cnt;

    // Controller: state, counters and every output are registered here
    always_ff @(posedge reg_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            beats     <= '0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b0;
            wd_ready  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            busy      <= 1'b0;
            reg_ce    <= 1'b0;
            reg_we    <= '0;
            reg_addr  <= '0;
            reg_wrd   <= '0;
        end else begin
            // Strobe is a one-cycle pulse; enables only ever accompany it
            reg_ce <= 1'b0;
            reg_we <= '0;

            case (state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cur_addr  <= cmd_addr;
                        beats     <= cmd_len;
                        if (cmd_wr) begin
                            wd_ready <= 1'b1;
                            state    <= S_WRITE;
                        end else begin
                            reg_ce   <= 1'b1;
                            reg_addr <= cmd_addr;
                            state    <= S_RADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                S_WRITE: begin
                    if (wd_valid && wd_ready) begin
                        reg_ce   <= 1'b1;
                        reg_we   <= '1;
                        reg_addr <= cur_addr;
                        reg_wrd  <= wd_data;
                        cur_addr <= cur_addr + 1'b1;
                        if (beats == '0) begin
                            wd_ready <= 1'b0;
                            state    <= S_WACK;
                        end else begin
                            beats <= beats - 1'b1;
                        end
                    end
                end

                // First WACK cycle carries the final strobe; ack rises one cycle later
                S_WACK: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                S_RADDR: begin
                    if (RD_LAT == 0) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= reg_rdd;
                        rsp_last  <= (beats == '0);
                        state     <= S_RRESP;
                    end else begin
                        wait_cnt <= 3'(WAIT_INIT);
                        state    <= S_RWAIT;
                    end
                end

                S_RWAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= reg_rdd;
                        rsp_last  <= (beats == '0);
                        state     <= S_RRESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                S_RRESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (beats == '0) begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            beats    <= beats - 1'b1;
                            cur_addr <= cur_addr + 1'b1;
                            reg_ce   <= 1'b1;
                            reg_addr <= cur_addr + 1'b1;
                            state    <= S_RADDR;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qwi_reg_master.sv
// tb_qwi_reg_master: directed bench for qwi_reg_master.
// Main instance uses RD_LAT=1 with a combinational rdd=addr*2 responder; two extra
// instances (RD_LAT=0 and RD_LAT=2) check read-sample timing.
module tb_qwi_reg_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wd_valid = 1'b0;
    logic [31:0] wd_data = '0;
    logic        rsp_ready = 1'b0;
    logic        cmd_ready, wd_ready, rsp_valid, rsp_last, busy, reg_ce;
    logic [31:0] rsp_data, reg_wrd, reg_rdd;
    logic [3:0]  reg_we;
    logic [11:0] reg_addr;

    assign reg_rdd = 32'(reg_addr) * 32'd2;

    qwi_reg_master u_dut (
        .reg_clk(clk), .sys_rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy),
        .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wrd(reg_wrd), .reg_rdd(reg_rdd)
    );

    // latency instances share command inputs, separate outputs
    logic        l_cmd_valid = 1'b0, l_rsp_ready = 1'b0, tie0 = 1'b0;
    logic [11:0] l_cmd_addr = '0;
    logic [7:0]  l_len = '0;
    logic [31:0] tie32 = '0;
    logic        a0_crdy, a0_wrdy, a0_rv, a0_last, a0_busy, a0_ce;
    logic        a2_crdy, a2_wrdy, a2_rv, a2_last, a2_busy, a2_ce;
    logic [31:0] a0_data, a0_wrd, a2_data, a2_wrd, a0_rdd;
    logic [31:0] a2_rdd = '0;
    logic [3:0]  a0_we, a2_we;
    logic [11:0] a0_addr, a2_addr;

    assign a0_rdd = 32'hA500_0000 | 32'(a0_addr);
    // RD_LAT=2 responder data follows the address one cycle late
    always @(posedge clk) a2_rdd <= 32'hA500_0000 | 32'(a2_addr);

    qwi_reg_master #(.RD_LAT(0)) u_lat0 (
        .reg_clk(clk), .sys_rst_n(rst_n),
        .cmd_valid(l_cmd_valid), .cmd_ready(a0_crdy), .cmd_wr(tie0),
        .cmd_addr(l_cmd_addr), .cmd_len(l_len),
        .wd_valid(tie0), .wd_ready(a0_wrdy), .wd_data(tie32),
        .rsp_valid(a0_rv), .rsp_ready(l_rsp_ready), .rsp_data(a0_data),
        .rsp_last(a0_last), .busy(a0_busy),
        .reg_ce(a0_ce), .reg_we(a0_we), .reg_addr(a0_addr),
        .reg_wrd(a0_wrd), .reg_rdd(a0_rdd)
    );

    qwi_reg_master #(.RD_LAT(2)) u_lat2 (
        .reg_clk(clk), .sys_rst_n(rst_n),
        .cmd_valid(l_cmd_valid), .cmd_ready(a2_crdy), .cmd_wr(tie0),
        .cmd_addr(l_cmd_addr), .cmd_len(l_len),
        .wd_valid(tie0), .wd_ready(a2_wrdy), .wd_data(tie32),
        .rsp_valid(a2_rv), .rsp_ready(l_rsp_ready), .rsp_data(a2_data),
        .rsp_last(a2_last), .busy(a2_busy),
        .reg_ce(a2_ce), .reg_we(a2_we), .reg_addr(a2_addr),
        .reg_wrd(a2_wrd), .reg_rdd(a2_rdd)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ce_cnt = 0;

    always @(negedge clk) if (reg_ce) ce_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the command handshake
    task automatic send_cmd(input logic wr, input logic [11:0] a, input logic [7:0] len);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_cmd", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_wait", 128'(rsp_valid), 128'(1));
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_wrd;
        logic [31:0] exp_rsp;
    } sv_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ce;
        logic [11:0] a;
        logic [31:0] wrd;
        logic        wrdy;
        logic        rv;
    } cv_t;

    sv_t sv_tab[5];
    cv_t cv_tab[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce0, k, k0, k2;
        logic [11:0] la;
        logic [11:0] exp_a [4];
        logic [31:0] dat [4];

        // single-access vectors: write/read one beat each
        sv_tab[0] = '{1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF, 12'h004, 32'hDEAD_BEEF, 32'h0};
        sv_tab[1] = '{1'b1, 12'hFFF, 32'h0000_0000, 4'hF, 12'hFFF, 32'h0000_0000, 32'h0};
        sv_tab[2] = '{1'b0, 12'h010, 32'h0,         4'h0, 12'h010, 32'h0,         32'h20};
        sv_tab[3] = '{1'b0, 12'hFFF, 32'h0,         4'h0, 12'hFFF, 32'h0,         32'h1FFE};
        sv_tab[4] = '{1'b1, 12'h0A5, 32'h1234_5678, 4'hF, 12'h0A5, 32'h1234_5678, 32'h0};

        // write len 2 at 0x100 with wd_valid gaps; expectations are for the next cycle
        cv_tab[0] = '{1'b1, 32'hA0A0_0000, 1'b1, 12'h100, 32'hA0A0_0000, 1'b1, 1'b0};
        cv_tab[1] = '{1'b0, 32'hBAD0_0001, 1'b0, 12'h100, 32'hA0A0_0000, 1'b1, 1'b0};
        cv_tab[2] = '{1'b0, 32'hBAD0_0002, 1'b0, 12'h100, 32'hA0A0_0000, 1'b1, 1'b0};
        cv_tab[3] = '{1'b1, 32'hA1A1_0001, 1'b1, 12'h101, 32'hA1A1_0001, 1'b1, 1'b0};
        cv_tab[4] = '{1'b0, 32'hBAD0_0004, 1'b0, 12'h101, 32'hA1A1_0001, 1'b1, 1'b0};
        cv_tab[5] = '{1'b1, 32'hA2A2_0002, 1'b1, 12'h102, 32'hA2A2_0002, 1'b0, 1'b0};
        cv_tab[6] = '{1'b0, 32'hBAD0_0006, 1'b0, 12'h102, 32'hA2A2_0002, 1'b0, 1'b1};

        // reset state
        @(negedge clk);
        chk("reset_ctl", 128'({cmd_ready, wd_ready, rsp_valid, rsp_last, busy, reg_ce, reg_we, reg_addr}), 128'(0));
        chk("reset_data", 128'({rsp_data, reg_wrd}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("post_reset_busy", 128'(busy), 128'(0));

        // single accesses
        for (int i = 0; i < 5; i++) begin
            send_cmd(sv_tab[i].wr, sv_tab[i].addr, 8'd0);
            chk("busy_after_cmd", 128'(busy), 128'(1));
            if (sv_tab[i].wr) begin
                chk("wd_ready_in_write", 128'(wd_ready), 128'(1));
                wd_valid = 1'b1;
                wd_data  = sv_tab[i].data;
                @(negedge clk);
                wd_valid = 1'b0;
                chk("single_wr_ce", 128'(reg_ce), 128'(1));
                chk("single_wr_we", 128'(reg_we), 128'(sv_tab[i].exp_we));
                chk("single_wr_addr", 128'(reg_addr), 128'(sv_tab[i].exp_addr));
                chk("single_wr_wrd", 128'(reg_wrd), 128'(sv_tab[i].exp_wrd));
                chk("single_wr_no_early_ack", 128'(rsp_valid), 128'(0));
                @(negedge clk);
            end else begin
                chk("single_rd_ce", 128'(reg_ce), 128'(1));
                chk("single_rd_we", 128'(reg_we), 128'(sv_tab[i].exp_we));
                chk("single_rd_addr", 128'(reg_addr), 128'(sv_tab[i].exp_addr));
                @(negedge clk);
                chk("single_rd_wait_ce", 128'(reg_ce), 128'(0));
                chk("single_rd_wait_rv", 128'(rsp_valid), 128'(0));
                @(negedge clk);
                chk("single_rd_addr_held", 128'(reg_addr), 128'(sv_tab[i].exp_addr));
            end
            chk("single_rsp_valid", 128'(rsp_valid), 128'(1));
            chk("single_rsp_data", 128'(rsp_data), 128'(sv_tab[i].exp_rsp));
            chk("single_rsp_last", 128'(rsp_last), 128'(1));
            chk("single_rsp_ce_low", 128'(reg_ce), 128'(0));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("single_done_rv", 128'(rsp_valid), 128'(0));
            chk("single_done_idle", 128'({cmd_ready, busy}), 128'(2'b10));
        end

        // write with wd_valid gaps, cycle by cycle
        ce0 = ce_cnt;
        send_cmd(1'b1, 12'h100, 8'd2);
        for (int i = 0; i < 7; i++) begin
            wd_valid = cv_tab[i].v;
            wd_data  = cv_tab[i].d;
            @(negedge clk);
            chk("gap_ce", 128'(reg_ce), 128'(cv_tab[i].ce));
            chk("gap_we", 128'(reg_we), 128'(cv_tab[i].ce ? 4'hF : 4'h0));
            chk("gap_addr", 128'(reg_addr), 128'(cv_tab[i].a));
            chk("gap_wrd", 128'(reg_wrd), 128'(cv_tab[i].wrd));
            chk("gap_wd_ready", 128'(wd_ready), 128'(cv_tab[i].wrdy));
            chk("gap_rsp_valid", 128'(rsp_valid), 128'(cv_tab[i].rv));
        end
        wd_valid = 1'b0;
        chk("gap_ack", 128'({rsp_data, rsp_last}), 128'({32'h0, 1'b1}));
        chk("gap_strobe_count", 128'(ce_cnt - ce0), 128'(3));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // read burst 0x010 len 3 with response stalls
        ce0 = ce_cnt;
        send_cmd(1'b0, 12'h010, 8'd3);
        for (int b = 0; b < 4; b++) begin
            wait_rsp();
            chk("burst_rd_data", 128'(rsp_data), 128'(32'h20 + 32'(2 * b)));
            chk("burst_rd_last", 128'(rsp_last), 128'(b == 3));
            chk("burst_rd_addr", 128'(reg_addr), 128'(12'h010 + 12'(b)));
            k = (b == 0) ? 2 : int'($urandom_range(0, 3));
            for (int s = 0; s < k; s++) begin
                @(negedge clk);
                chk("stall_rv", 128'(rsp_valid), 128'(1));
                chk("stall_data", 128'(rsp_data), 128'(32'h20 + 32'(2 * b)));
                chk("stall_addr", 128'(reg_addr), 128'(12'h010 + 12'(b)));
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        chk("burst_rd_done", 128'({rsp_valid, cmd_ready}), 128'(2'b01));
        chk("burst_rd_strobes", 128'(ce_cnt - ce0), 128'(4));

        // write burst across the address wrap, wd_valid every cycle
        exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
        dat[0] = 32'h1111_0000; dat[1] = 32'h2222_0001; dat[2] = 32'h3333_0002; dat[3] = 32'h4444_0003;
        ce0 = ce_cnt;
        send_cmd(1'b1, 12'hFFE, 8'd3);
        wd_valid = 1'b1;
        wd_data  = dat[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrap_ce", 128'(reg_ce), 128'(1));
            chk("wrap_addr", 128'(reg_addr), 128'(exp_a[i]));
            chk("wrap_wrd", 128'(reg_wrd), 128'(dat[i]));
            if (i < 3) wd_data = dat[i + 1];
            else wd_valid = 1'b0;
        end
        @(negedge clk);
        chk("wrap_ack", 128'({rsp_valid, rsp_last, rsp_data, reg_ce}), 128'({1'b1, 1'b1, 32'h0, 1'b0}));
        chk("wrap_strobes", 128'(ce_cnt - ce0), 128'(4));

        // ack and new command offered in the same cycle: command waits for IDLE
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 12'h200;
        cmd_len   = 8'd0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("overlap_idle", 128'({rsp_valid, cmd_ready, busy, reg_ce}), 128'(4'b0100));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("overlap_accept", 128'({reg_ce, busy, cmd_ready, reg_addr}), 128'({3'b110, 12'h200}));
        wait_rsp();
        chk("overlap_rd_data", 128'({rsp_data, rsp_last}), 128'({32'h400, 1'b1}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("single_ack_only", 128'(rsp_valid), 128'(0));

        // read latency 0 and 2
        for (int j = 0; j < 2; j++) begin
            la = (j == 0) ? 12'h123 : 12'hFFF;
            chk("lat_cmd_ready", 128'({a0_crdy, a2_crdy}), 128'(2'b11));
            l_cmd_addr  = la;
            l_cmd_valid = 1'b1;
            @(negedge clk);
            l_cmd_valid = 0;
            chk("lat_raddr_ce", 128'({a0_ce, a2_ce}), 128'(2'b11));
            k0 = 0;
            k2 = 0;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                if (a0_rv && k0 == 0) k0 = c;
                if (a2_rv && k2 == 0) k2 = c;
            end
            chk("lat0_spacing", 128'(k0), 128'(1));
            chk("lat2_spacing", 128'(k2), 128'(3));
            chk("lat0_data", 128'(a0_data), 128'(32'hA500_0000 | 32'(la)));
            chk("lat2_data", 128'(a2_data), 128'(32'hA500_0000 | 32'(la)));
            chk("lat_last", 128'({a0_last, a2_last}), 128'(2'b11));
            chk("lat2_addr_held", 128'(a2_addr), 128'(la));
            l_rsp_ready = 1'b1;
            @(negedge clk);
            l_rsp_ready = 1'b0;
            chk("lat_done", 128'({a0_rv, a2_rv}), 128'(0));
            @(negedge clk);
        end

        // reset during beat 2 of a 4-beat read
        rsp_ready = 1'b1;
        send_cmd(1'b0, 12'h040, 8'd3);
        k = 0;
        for (int c = 0; c < 40 && k < 2; c++) begin
            if (rsp_valid) k++;
            if (k < 2) @(negedge clk);
        end
        chk("abort_two_beats_done", 128'(k), 128'(2));
        @(negedge clk);
        chk("abort_beat2_raddr", 128'({reg_ce, reg_addr}), 128'({1'b1, 12'h042}));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async_ctl", 128'({cmd_ready, wd_ready, rsp_valid, rsp_last, busy, reg_ce, reg_we, reg_addr}), 128'(0));
        chk("abort_async_data", 128'({rsp_data, reg_wrd}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release", 128'({cmd_ready, rsp_valid, busy, reg_ce}), 128'(4'b1000));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_stale_rsp", 128'({rsp_valid, reg_ce}), 128'(0));
        end
        rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
